// File: rtl/fourmux_arbiter_pkg.sv
// Shared types and helpers for the fourmux round-robin arbiter.
package fourmux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned N_REQ = 4;

    // The mux gates input Dk with S = {k[0], k[1]}, so the index bits are swapped.
    function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
        return {idx[0], idx[1]};
    endfunction

endpackage

// File: rtl/fourmux_arbiter_if.sv
// Request/grant bundle between the requesting units and the arbiter.
interface fourmux_arbiter_if;

    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [1:0] owner;
    logic       busy;

    modport master (output req, input gnt, input sel, input owner, input busy);
    modport slave  (input req, output gnt, output sel, output owner, output busy);

endinterface

// File: rtl/fourmux_arbiter_rr_pick4.sv
// Combinational round-robin picker: first eligible request searching upward
// from last+1, wrapping modulo 4, optionally skipping one index.
module rr_pick4
    import fourmux_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    input  logic       exclude_en,
    input  logic [1:0] exclude_idx,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Scan the four positions after last in priority order; the first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = last + 2'(i);
            if (!found && req[cand] && !(exclude_en && (cand == exclude_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fourmux_arbiter.sv
// Round-robin arbiter and select sequencer for the shared four-way mux.
module fourmux_arbiter
    import fourmux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
)
(
    input  logic             clk,
    input  logic             reset,
    fourmux_arbiter_if.slave bus
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
    localparam logic       HOLD_EN  = (MAX_HOLD != 0);

    arb_state_e state_q;
    logic [1:0] last_q;
    logic [1:0] owner_q;
    logic [7:0] cnt_q;
    logic [3:0] gnt_q;
    logic [1:0] sel_q;
    logic       busy_q;

    logic       pick_found;
    logic [1:0] pick_idx;
    logic       owner_req;
    logic       take_new;
    logic       go_idle;
    logic       hold_inc;

    // While granted, the owner is excluded so "found" also means "someone else waits".
    rr_pick4 u_pick (
        .req         (bus.req),
        .last        (last_q),
        .exclude_en  (state_q == GRANT),
        .exclude_idx (owner_q),
        .found       (pick_found),
        .idx         (pick_idx)
    );

    // Decide between new grant (start/rotate/handover), release to idle, or hold.
    always_comb begin
        take_new  = 1'b0;
        go_idle   = 1'b0;
        hold_inc  = 1'b0;
        owner_req = bus.req[owner_q];
        case (state_q)
            IDLE: take_new = pick_found;
            GRANT: begin
                if (owner_req) begin
                    if (HOLD_EN && (cnt_q == HOLD_LIM) && pick_found) begin
                        take_new = 1'b1;
                    end else if (HOLD_EN && (cnt_q != HOLD_LIM)) begin
                        hold_inc = 1'b1;
                    end
                end else begin
                    take_new = pick_found;
                    go_idle  = !pick_found;
                end
            end
            default: ;
        endcase
    end

    // State, hold counter, last owner and registered outputs update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
        end else if (take_new) begin
            state_q <= GRANT;
            last_q  <= pick_idx;
            owner_q <= pick_idx;
            cnt_q   <= 8'd1;
            gnt_q   <= 4'b0001 << pick_idx;
            sel_q   <= idx_to_sel(pick_idx);
            busy_q  <= 1'b1;
        end else if (go_idle) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
        end else if (hold_inc) begin
            cnt_q   <= cnt_q + 8'd1;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_fourmux_arbiter.sv
// Scoreboard bench for fourmux_arbiter: three instances (MAX_HOLD 8, 2, 0)
// share req/reset; per-instance expectation queues are drained by a monitor.
module tb_fourmux_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [1:0] owner;
        logic       busy;
    } exp_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] req_tb = '0;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t  qe0[$], qe1[$], qe2[$];
    string qn0[$], qn1[$], qn2[$];

    fourmux_arbiter_if if8 ();
    fourmux_arbiter_if if2 ();
    fourmux_arbiter_if if0 ();

    assign if8.req = req_tb;
    assign if2.req = req_tb;
    assign if0.req = req_tb;

    fourmux_arbiter #(.MAX_HOLD(8)) u_m8 (.clk(clk), .reset(reset), .bus(if8.slave));
    fourmux_arbiter #(.MAX_HOLD(2)) u_m2 (.clk(clk), .reset(reset), .bus(if2.slave));
    fourmux_arbiter #(.MAX_HOLD(0)) u_m0 (.clk(clk), .reset(reset), .bus(if0.slave));

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic cyc(input logic [3:0] r, input logic rst);
        @(negedge clk);
        req_tb = r;
        reset  = rst;
    endtask

    // mask bit0 = MAX_HOLD 8, bit1 = MAX_HOLD 2, bit2 = MAX_HOLD 0
    task automatic push_exp(input logic [2:0] mask, input logic [3:0] g, input logic [1:0] s,
                            input logic [1:0] o, input logic b, input string nm);
        exp_t e;
        e = '{gnt: g, sel: s, owner: o, busy: b};
        if (mask[0]) begin qe0.push_back(e); qn0.push_back(nm); end
        if (mask[1]) begin qe1.push_back(e); qn1.push_back(nm); end
        if (mask[2]) begin qe2.push_back(e); qn2.push_back(nm); end
    endtask

    task automatic check(input string dut, input string nm, input exp_t e, input exp_t a);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s/%s: got gnt=%b sel=%b owner=%0d busy=%b, want gnt=%b sel=%b owner=%0d busy=%b",
                     dut, nm, a.gnt, a.sel, a.owner, a.busy, e.gnt, e.sel, e.owner, e.busy);
        end
    endtask

    // Monitor: sample shortly after each rising edge and retire pending expectations.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (qe0.size() > 0) check("m8", qn0.pop_front(), qe0.pop_front(), exp_t'({if8.gnt, if8.sel, if8.owner, if8.busy}));
            if (qe1.size() > 0) check("m2", qn1.pop_front(), qe1.pop_front(), exp_t'({if2.gnt, if2.sel, if2.owner, if2.busy}));
            if (qe2.size() > 0) check("m0", qn2.pop_front(), qe2.pop_front(), exp_t'({if0.gnt, if0.sel, if0.owner, if0.busy}));
        end
    end

    // Stimulus: directed vectors with hand-computed expectations.
    initial begin
        int         rot_own [10];
        logic [1:0] rot_sel [10];
        logic [1:0] o;
        logic [1:0] s;

        rot_own = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        rot_sel = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};

        // reset and idle
        cyc(4'b0000, 1'b1); push_exp(3'b111, 4'b0000, 2'b00, 2'd0, 1'b0, "reset");
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0000, 1'b0); push_exp(3'b111, 4'b0000, 2'b00, 2'd0, 1'b0, "idle");
        end

        // single request from requester 2, then release
        cyc(4'b0100, 1'b0); push_exp(3'b111, 4'b0100, 2'b01, 2'd2, 1'b1, "single_req2");
        cyc(4'b0000, 1'b0); push_exp(3'b111, 4'b0000, 2'b00, 2'd0, 1'b0, "single_release");

        // all request, MAX_HOLD=2 rotates every 2 cycles
        cyc(4'b0000, 1'b1); push_exp(3'b111, 4'b0000, 2'b00, 2'd0, 1'b0, "reset_rot");
        for (int i = 0; i < 10; i++) begin
            o = 2'(rot_own[i]);
            cyc(4'b1111, 1'b0); push_exp(3'b010, 4'b0001 << o, rot_sel[i], o, 1'b1, "rot_m2");
        end
        cyc(4'b0000, 1'b0); push_exp(3'b010, 4'b0000, 2'b00, 2'd0, 1'b0, "rot_release");

        // zero-bubble handover from 1 to 3
        cyc(4'b0000, 1'b1); push_exp(3'b111, 4'b0000, 2'b00, 2'd0, 1'b0, "reset_ho");
        cyc(4'b1010, 1'b0); push_exp(3'b111, 4'b0010, 2'b10, 2'd1, 1'b1, "ho_grant1");
        cyc(4'b1010, 1'b0); push_exp(3'b111, 4'b0010, 2'b10, 2'd1, 1'b1, "ho_hold1");
        cyc(4'b1000, 1'b0); push_exp(3'b111, 4'b1000, 2'b11, 2'd3, 1'b1, "ho_handover");
        cyc(4'b0000, 1'b0); push_exp(3'b111, 4'b0000, 2'b00, 2'd0, 1'b0, "ho_idle");

        // req=0011 for 20 cycles: unlimited hold vs 8-cycle rotation
        cyc(4'b0000, 1'b1); push_exp(3'b111, 4'b0000, 2'b00, 2'd0, 1'b0, "reset_hold");
        for (int i = 1; i <= 20; i++) begin
            cyc(4'b0011, 1'b0);
            push_exp(3'b100, 4'b0001, 2'b00, 2'd0, 1'b1, "hold_m0");
            if (i >= 9 && i <= 16) begin o = 2'd1; s = 2'b10; end
            else begin o = 2'd0; s = 2'b00; end
            push_exp(3'b001, 4'b0001 << o, s, o, 1'b1, "rot_m8");
        end
        cyc(4'b0000, 1'b0); push_exp(3'b101, 4'b0000, 2'b00, 2'd0, 1'b0, "hold_release");

        // reset in the middle of a grant to requester 3
        cyc(4'b0000, 1'b1); push_exp(3'b111, 4'b0000, 2'b00, 2'd0, 1'b0, "reset_mid");
        cyc(4'b1000, 1'b0); push_exp(3'b111, 4'b1000, 2'b11, 2'd3, 1'b1, "grant3");
        cyc(4'b1000, 1'b0); push_exp(3'b111, 4'b1000, 2'b11, 2'd3, 1'b1, "grant3_hold");
        cyc(4'b1000, 1'b1); push_exp(3'b111, 4'b0000, 2'b00, 2'd0, 1'b0, "midgrant_reset");
        cyc(4'b1001, 1'b0); push_exp(3'b111, 4'b0001, 2'b00, 2'd0, 1'b1, "post_reset_req0");
        cyc(4'b1000, 1'b0); push_exp(3'b111, 4'b1000, 2'b11, 2'd3, 1'b1, "drop_handover");
        cyc(4'b1001, 1'b0); push_exp(3'b111, 4'b1000, 2'b11, 2'd3, 1'b1, "reraise_ignored");
        cyc(4'b0000, 1'b0); push_exp(3'b111, 4'b0000, 2'b00, 2'd0, 1'b0, "final_idle");

        // bounded drain of outstanding expectations
        for (int i = 0; i < 5; i++) begin
            if (qe0.size() + qe1.size() + qe2.size() != 0) @(negedge clk);
        end
        n_checks++;
        if (qe0.size() + qe1.size() + qe2.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", qe0.size() + qe1.size() + qe2.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
